// File: rtl/aes_pipe_arbiter_if.sv
// Requester, core and status signals of the shared AES pipeline arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface aes_pipe_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 5
);
  logic                     issue_en;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*128-1:0]   req_plaintext;
  logic [NUM_REQ*128-1:0]   req_key;
  logic                     core_valid_in;
  logic [127:0]             core_plaintext;
  logic [127:0]             core_key;
  logic                     core_valid_output;
  logic [127:0]             core_ciphertext;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [127:0]             rsp_ciphertext;
  logic [CNT_W-1:0]         in_flight;
  logic                     drained;
  logic                     tag_error;

  modport slave (
    input  issue_en, req_valid, req_plaintext, req_key,
    input  core_valid_output, core_ciphertext,
    output req_ready, core_valid_in, core_plaintext, core_key,
    output rsp_valid, rsp_ciphertext, in_flight, drained, tag_error
  );

  modport master (
    output issue_en, req_valid, req_plaintext, req_key,
    output core_valid_output, core_ciphertext,
    input  req_ready, core_valid_in, core_plaintext, core_key,
    input  rsp_valid, rsp_ciphertext, in_flight, drained, tag_error
  );
endinterface

// File: rtl/aes_pipe_arbiter.sv
// Round-robin sharing of one fixed-latency AES-128 core between NUM_REQ requesters,
// with a requester-ID shadow pipe that routes each ciphertext back to its owner.
module aes_pipe_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int CORE_LAT = 11,
  parameter int CNT_W    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  aes_pipe_arbiter_if.slave      bus
);

  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gnt_id;
  logic                xfer;
  logic                found;
  int                  idx;

  logic                core_valid_in_q, core_valid_in_d;
  logic [127:0]        core_pt_q, core_pt_d;
  logic [127:0]        core_key_q, core_key_d;

  logic [CORE_LAT-1:0] tag_v_q, tag_v_d;
  logic [ID_W-1:0]     tag_id_q [CORE_LAT];
  logic [ID_W-1:0]     tag_id_d [CORE_LAT];
  logic                head_v;
  logic [ID_W-1:0]     head_id;
  logic                retire;

  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [127:0]        rsp_ct_q, rsp_ct_d;
  logic [CNT_W-1:0]    in_flight_q, in_flight_d;
  logic                tag_error_q, tag_error_d;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant  = '0;
    gnt_id = ptr_q;
    found  = 1'b0;
    idx    = 0;
    if (!reset && bus.issue_en) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && bus.req_valid[idx]) begin
          grant[idx] = 1'b1;
          gnt_id     = ID_W'(idx);
          found      = 1'b1;
        end
      end
    end
  end

  assign xfer = found;

  always_comb begin
    ptr_d           = ptr_q;
    core_valid_in_d = 1'b0;
    core_pt_d       = core_pt_q;
    core_key_d      = core_key_q;
    if (xfer) begin
      ptr_d           = gnt_id;
      core_valid_in_d = 1'b1;
      core_pt_d       = bus.req_plaintext[128*int'(gnt_id) +: 128];
      core_key_d      = bus.req_key[128*int'(gnt_id) +: 128];
    end
  end

  // ptr_q equals the ID of the block currently presented to the core.
  always_comb begin
    tag_v_d     = {tag_v_q[CORE_LAT-2:0], core_valid_in_q};
    tag_id_d[0] = ptr_q;
    for (int i = 1; i < CORE_LAT; i++) tag_id_d[i] = tag_id_q[i-1];
  end

  assign head_v  = tag_v_q[CORE_LAT-1];
  assign head_id = tag_id_q[CORE_LAT-1];
  assign retire  = bus.core_valid_output & head_v;

  always_comb begin
    rsp_valid_d = '0;
    rsp_ct_d    = rsp_ct_q;
    if (retire) begin
      rsp_valid_d[head_id] = 1'b1;
      rsp_ct_d             = bus.core_ciphertext;
    end
    in_flight_d = in_flight_q;
    if (xfer && !retire)      in_flight_d = in_flight_q + CNT_W'(1);
    else if (!xfer && retire) in_flight_d = in_flight_q - CNT_W'(1);
    tag_error_d = tag_error_q | (bus.core_valid_output != head_v);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q           <= ID_W'(NUM_REQ-1);
      core_valid_in_q <= 1'b0;
      core_pt_q       <= '0;
      core_key_q      <= '0;
      tag_v_q         <= '0;
      for (int i = 0; i < CORE_LAT; i++) tag_id_q[i] <= '0;
      rsp_valid_q     <= '0;
      rsp_ct_q        <= '0;
      in_flight_q     <= '0;
      tag_error_q     <= 1'b0;
    end else begin
      ptr_q           <= ptr_d;
      core_valid_in_q <= core_valid_in_d;
      core_pt_q       <= core_pt_d;
      core_key_q      <= core_key_d;
      tag_v_q         <= tag_v_d;
      for (int i = 0; i < CORE_LAT; i++) tag_id_q[i] <= tag_id_d[i];
      rsp_valid_q     <= rsp_valid_d;
      rsp_ct_q        <= rsp_ct_d;
      in_flight_q     <= in_flight_d;
      tag_error_q     <= tag_error_d;
    end
  end

  assign bus.req_ready      = grant;
  assign bus.core_valid_in  = core_valid_in_q;
  assign bus.core_plaintext = core_pt_q;
  assign bus.core_key       = core_key_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_ciphertext = rsp_ct_q;
  assign bus.in_flight      = in_flight_q;
  assign bus.drained        = !bus.issue_en && (in_flight_q == '0);
  assign bus.tag_error      = tag_error_q;

endmodule

// File: tb/tb_aes_pipe_arbiter.sv
// Bench for aes_pipe_arbiter: fixed-latency core stand-in plus a timestamped
// expected-response queue as the reference model.
module tb_aes_pipe_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 11;
  localparam int CW  = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_pipe_arbiter_if #(.NUM_REQ(N), .CNT_W(CW)) bus ();

  aes_pipe_arbiter #(.NUM_REQ(N), .ID_W(IDW), .CORE_LAT(LAT), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Core stand-in: known vectors map to their AES results, anything else to a keyed mix.
  function automatic logic [127:0] core_f(input logic [127:0] pt, input logic [127:0] key);
    if (pt == 128'h3243f6a8885a308d313198a2e0370734 && key == 128'h2b7e151628aed2a6abf7158809cf4f3c)
      return 128'h3925841d02dc09fbdc118597196a0b32;
    if (pt == '0 && key == '0) return 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    if (pt == '1 && key == '1) return 128'hd6ef5264e78ae67a5f1eab29f1e078c0;
    return pt ^ {key[63:0], key[127:64]} ^ 128'ha5a5_0f0f_3c3c_9696_c3c3_f0f0_5a5a_6969;
  endfunction

  logic         cv_pipe [LAT];
  logic [127:0] ct_pipe [LAT];
  logic         spurious;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        cv_pipe[i] <= 1'b0;
        ct_pipe[i] <= '0;
      end
    end else begin
      cv_pipe[0] <= bus.core_valid_in;
      ct_pipe[0] <= core_f(bus.core_plaintext, bus.core_key);
      for (int i = 1; i < LAT; i++) begin
        cv_pipe[i] <= cv_pipe[i-1];
        ct_pipe[i] <= ct_pipe[i-1];
      end
    end
  end

  assign bus.core_valid_output = cv_pipe[LAT-1] | spurious;
  assign bus.core_ciphertext   = ct_pipe[LAT-1];

  typedef struct {
    int           due;
    int           id;
    logic [127:0] ct;
  } exp_t;

  exp_t         exp_q[$];
  int           edge_n;
  int           m_ptr;
  logic         m_err;
  logic [127:0] m_pt, m_key, m_rct;
  int           n_chk, n_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      bus.req_plaintext[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
      bus.req_key[128*i +: 128]       = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // One clock: check the grant before the edge, advance the model, check registered outputs after.
  task automatic tick();
    int             gid;
    logic [N-1:0]   exp_rdy;
    logic [N-1:0]   exp_rsp;
    logic           due_now;
    exp_t           e;
    @(negedge clk);
    gid     = -1;
    exp_rdy = '0;
    if (!reset && bus.issue_en) begin
      for (int k = 1; k <= N; k++)
        if (gid < 0 && bus.req_valid[(m_ptr + k) % N]) gid = (m_ptr + k) % N;
    end
    if (gid >= 0) exp_rdy[gid] = 1'b1;
    chk("req_ready", 128'(bus.req_ready), 128'(exp_rdy));
    @(posedge clk);
    edge_n++;
    exp_rsp = '0;
    due_now = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
    if (reset) begin
      exp_q.delete();
      m_ptr = N - 1;
      m_err = 1'b0;
      m_pt  = '0;
      m_key = '0;
      m_rct = '0;
    end else begin
      if (spurious && !due_now) m_err = 1'b1;
      if (due_now) begin
        e = exp_q.pop_front();
        exp_rsp[e.id] = 1'b1;
        m_rct = e.ct;
      end
      if (gid >= 0) begin
        m_ptr = gid;
        m_pt  = bus.req_plaintext[128*gid +: 128];
        m_key = bus.req_key[128*gid +: 128];
        e.due = edge_n + LAT + 1;
        e.id  = gid;
        e.ct  = core_f(m_pt, m_key);
        exp_q.push_back(e);
      end
    end
    #1;
    chk("core_valid_in", 128'(bus.core_valid_in), 128'(gid >= 0));
    chk("core_plaintext", bus.core_plaintext, m_pt);
    chk("core_key", bus.core_key, m_key);
    chk("rsp_valid", 128'(bus.rsp_valid), 128'(exp_rsp));
    chk("rsp_ciphertext", bus.rsp_ciphertext, m_rct);
    chk("in_flight", 128'(bus.in_flight), 128'(exp_q.size()));
    chk("tag_error", 128'(bus.tag_error), 128'(m_err));
    chk("drained", 128'(bus.drained), 128'(!bus.issue_en && exp_q.size() == 0));
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    edge_n   = 0;
    m_ptr    = N - 1;
    m_err    = 1'b0;
    m_pt     = '0;
    m_key    = '0;
    m_rct    = '0;
    spurious = 1'b0;
    reset    = 1'b1;
    bus.issue_en = 1'b1;
    bus.req_valid = '1;
    rand_data();
    repeat (2) tick();
    reset = 1'b0;
    bus.req_valid = '0;
    tick();

    // single known vector from requester 0
    bus.req_plaintext[127:0] = 128'h3243f6a8885a308d313198a2e0370734;
    bus.req_key[127:0]       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    repeat (14) tick();

    // round-robin with all requesters busy
    bus.req_valid = '1;
    repeat (8) begin
      rand_data();
      tick();
    end
    bus.req_valid = '0;
    repeat (14) tick();

    // back-to-back known vectors on requesters 1 and 2
    bus.req_plaintext[255:128] = '0;
    bus.req_key[255:128]       = '0;
    bus.req_plaintext[383:256] = '1;
    bus.req_key[383:256]       = '1;
    bus.req_valid = 4'b0110;
    tick();
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    repeat (14) tick();

    // randomized traffic with occasional drain cycles
    repeat (300) begin
      rand_data();
      bus.req_valid = N'($urandom);
      bus.issue_en  = ($urandom_range(0, 7) != 0);
      tick();
    end
    bus.issue_en  = 1'b1;
    bus.req_valid = '0;
    repeat (14) tick();

    // drain with requests still pending
    bus.req_valid = '1;
    repeat (5) begin
      rand_data();
      tick();
    end
    bus.issue_en = 1'b0;
    repeat (15) tick();
    bus.issue_en  = 1'b1;
    bus.req_valid = '0;
    tick();

    // reset while blocks are in flight
    bus.req_valid = '1;
    repeat (3) begin
      rand_data();
      tick();
    end
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    rand_data();
    tick();
    bus.req_valid = '0;
    repeat (14) tick();

    // spurious core output with an empty tag pipe
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    repeat (3) tick();
    bus.req_valid = 4'b0001;
    rand_data();
    tick();
    bus.req_valid = '0;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
